// File: rtl/bk_subtract_pipe.sv
// ---------------------------------------------------------------------------
// bk_subtract_pipe
//
// Two-stage pipelined Brent-Kung prefix subtractor: diff = a - b computed as
// a + ~b + 1, with the +1 folded into the bit-0 group generate of the prefix
// tree. Flow control is valid/ready on both sides; in_ready is combinational
// from out_ready so a full pipe can accept and drain in the same cycle.
//
// Optional build macro:
//   BK_SUB_SATURATE_EN  clamp diff to the signed limit of a's sign on
//                       overflow (flags still reflect the unclamped result).
//
// Parameters:
//   WIDTH      operand width, power of two, >= 4
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair a/b presented
//   in_ready   block accepts operands this cycle
//   a, b       minuend / subtrahend
//   out_valid  result valid
//   out_ready  downstream accepts result
//   diff       a - b modulo 2^WIDTH (clamped when saturation is built in)
//   borrow     unsigned a < b
//   zero       diff == 0
//   overflow   signed two's-complement overflow of a - b
// ---------------------------------------------------------------------------
module bk_subtract_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             overflow
);

  localparam int LOG_W = $clog2(WIDTH);
  // Up-sweep levels resolved before the stage-1 register; the rest go in S2.
  localparam int UP_P1 = LOG_W / 2;

`ifdef BK_SUB_SATURATE_EN
  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic signed [WIDTH-1:0] sat_diff(
    input logic signed [WIDTH-1:0] d,
    input logic                    ovf,
    input logic                    a_neg
  );
    if (!ovf) return d;
    return a_neg ? SMIN : SMAX;
  endfunction
`endif

  logic             vld_p1, vld_p2;
  logic             load_p1, load_p2;

  logic [WIDTH-1:0] p_raw_s1;
  logic [WIDTH-1:0] g_s1, pb_s1;
  logic [WIDTH-1:0] g_p1, pb_p1, p_p1;
  logic             a_msb_p1, b_msb_p1;

  logic [WIDTH-1:0] g_s2, pb_s2;
  logic [WIDTH-1:0] carry_s2;
  logic signed [WIDTH-1:0] diff_s2;
  logic             cout_s2, ovf_s2;

  assign load_p2   = ~vld_p2 | out_ready;
  assign load_p1   = ~vld_p1 | load_p2;
  assign in_ready  = load_p1;
  assign out_valid = vld_p2;

  // ---- Stage 1: bitwise G/P and the first half of the up-sweep ----
  assign p_raw_s1 = a ^ ~b;

  always_comb begin
    g_s1    = a & ~b;
    pb_s1   = p_raw_s1;
    // Carry-in of 1 absorbed here, so group 0 generate already covers it.
    g_s1[0] = g_s1[0] | pb_s1[0];
    for (int k = 1; k <= UP_P1; k++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (((i + 1) & ((1 << k) - 1)) == 0) begin
          g_s1[i]  = g_s1[i] | (pb_s1[i] & g_s1[i - (1 << (k - 1))]);
          pb_s1[i] = pb_s1[i] & pb_s1[i - (1 << (k - 1))];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (load_p1) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (load_p1 && in_valid) begin
      g_p1     <= g_s1;
      pb_p1    <= pb_s1;
      p_p1     <= p_raw_s1;
      a_msb_p1 <= a[WIDTH-1];
      b_msb_p1 <= b[WIDTH-1];
    end
  end

  // ---- Stage 2: finish up-sweep, down-sweep fill, sum and flags ----
  always_comb begin
    g_s2  = g_p1;
    pb_s2 = pb_p1;
    for (int k = UP_P1 + 1; k <= LOG_W; k++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (((i + 1) & ((1 << k) - 1)) == 0) begin
          g_s2[i]  = g_s2[i] | (pb_s2[i] & g_s2[i - (1 << (k - 1))]);
          pb_s2[i] = pb_s2[i] & pb_s2[i - (1 << (k - 1))];
        end
      end
    end
    // Gray cells: position i picks up the completed prefix ending 2^(k-1)
    // bits below it, filling the gaps the up-sweep left.
    for (int k = LOG_W - 1; k >= 1; k--) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((((i + 1) & ((1 << k) - 1)) == (1 << (k - 1))) && (i >= (1 << k))) begin
          g_s2[i] = g_s2[i] | (pb_s2[i] & g_s2[i - (1 << (k - 1))]);
        end
      end
    end
  end

  // g_s2[i] is now the carry out of bit i; carry into bit 0 is the +1.
  assign carry_s2 = {g_s2[WIDTH-2:0], 1'b1};
  assign diff_s2  = p_p1 ^ carry_s2;
  assign cout_s2  = g_s2[WIDTH-1];
  assign ovf_s2   = (a_msb_p1 ^ b_msb_p1) & (diff_s2[WIDTH-1] ^ a_msb_p1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2   <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else if (load_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
`ifdef BK_SUB_SATURATE_EN
        diff   <= sat_diff(diff_s2, ovf_s2, a_msb_p1);
`else
        diff   <= diff_s2;
`endif
        borrow   <= ~cout_s2;
        zero     <= ~|diff_s2;
        overflow <= ovf_s2;
      end
    end
  end

endmodule

// File: tb/tb_bk_subtract_pipe.sv
module tb_bk_subtract_pipe;
  localparam int W = 32;

`ifdef BK_SUB_SATURATE_EN
  localparam logic [W-1:0] EXP_OV_NEG = 32'h8000_0000;
  localparam logic [W-1:0] EXP_OV_POS = 32'h7FFF_FFFF;
`else
  localparam logic [W-1:0] EXP_OV_NEG = 32'h7FFF_FFFF;
  localparam logic [W-1:0] EXP_OV_POS = 32'h8000_0000;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, diff;
  logic         borrow, zero, overflow;

  always #5 clk = ~clk;

  bk_subtract_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow), .zero(zero), .overflow(overflow)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         z;
    logic         ov;
  } res_t;

  res_t         q[$];
  int           checks = 0;
  int           errors = 0;
  logic         stall_prev = 1'b0;
  logic [W-1:0] diff_prev = '0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] d,
                         input logic bo, input logic z, input logic ov);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".diff"}, diff, d);
    chk({tag, ".borrow"}, 32'(borrow), 32'(bo));
    chk({tag, ".zero"}, 32'(zero), 32'(z));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ov));
  endtask

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    res_t       r;
    logic [W:0] t;
    t    = {1'b0, x} - {1'b0, y};
    r.d  = t[W-1:0];
    r.bo = t[W];
    r.z  = (r.d == '0);
    r.ov = (x[W-1] != y[W-1]) && (r.d[W-1] != x[W-1]);
`ifdef BK_SUB_SATURATE_EN
    if (r.ov) r.d = x[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return r;
  endfunction

  // One handshake cycle: drive at negedge, score outputs, record acceptance.
  task automatic cyc(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                     input logic ordy);
    res_t e;
    @(negedge clk);
    if (stall_prev) begin
      chk("stall.hold_valid", 32'(out_valid), 32'd1);
      chk("stall.hold_diff", diff, diff_prev);
    end
    in_valid  = iv;
    a         = ia;
    b         = ib;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("sb.spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        chk("sb.diff", diff, e.d);
        chk("sb.borrow", 32'(borrow), 32'(e.bo));
        chk("sb.zero", 32'(zero), 32'(e.z));
        chk("sb.overflow", 32'(overflow), 32'(e.ov));
      end
    end
    if (in_valid && in_ready) q.push_back(model(ia, ib));
    stall_prev = out_valid && !out_ready;
    diff_prev  = diff;
  endtask

  logic [W-1:0] pa [8];
  logic [W-1:0] pb [8];
  logic [W-1:0] corner [6];
  int           sent;
  int           cyc_cnt;
  logic [W-1:0] ra, rb;

  initial begin
    corner[0] = 32'h0000_0000; corner[1] = 32'hFFFF_FFFF;
    corner[2] = 32'h8000_0000; corner[3] = 32'h7FFF_FFFF;
    corner[4] = 32'h0000_0001; corner[5] = 32'h8000_0001;

    // ---- reset state ----
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.diff", diff, 32'd0);
    chk("rst.flags", {29'd0, borrow, zero, overflow}, 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // ---- directed vectors, latency 2, back to back ----
    @(negedge clk); in_valid = 1'b1; a = 32'd5; b = 32'd3; out_ready = 1'b1;
    @(negedge clk); chk("lat1.out_valid", 32'(out_valid), 32'd0);
                    a = 32'd3; b = 32'd5;
    @(negedge clk); chk_out("sub5_3", 32'h0000_0002, 1'b0, 1'b0, 1'b0);
                    a = 32'hDEAD_BEEF; b = 32'hDEAD_BEEF;
    @(negedge clk); chk_out("sub3_5", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
                    a = 32'h8000_0000; b = 32'h0000_0001;
    @(negedge clk); chk_out("equal", 32'h0000_0000, 1'b0, 1'b1, 1'b0);
                    a = 32'h7FFF_FFFF; b = 32'hFFFF_FFFF;
    @(negedge clk); chk_out("ovf_neg_a", EXP_OV_NEG, 1'b0, 1'b0, 1'b1);
                    in_valid = 1'b0;
    @(negedge clk); chk_out("ovf_pos_a", EXP_OV_POS, 1'b1, 1'b0, 1'b1);
    @(negedge clk); chk("bubble.out_valid", 32'(out_valid), 32'd0);

    // ---- 8 pairs with out_ready low for cycles 3..7 ----
    for (int i = 0; i < 8; i++) begin
      pa[i] = $urandom;
      pb[i] = $urandom;
    end
    sent = 0;
    for (int t = 0; t < 40 && (sent < 8 || q.size() > 0); t++) begin
      cyc(sent < 8, pa[sent & 7], pb[sent & 7], !(t >= 3 && t <= 7));
      if (t >= 3 && t <= 7) chk("stall.in_ready", 32'(in_ready), 32'd0);
      if (in_valid && in_ready) sent++;
    end
    chk("stall.sent", 32'(sent), 32'd8);
    chk("stall.drained", 32'(q.size()), 32'd0);

    // ---- asynchronous reset with both stages full ----
    @(negedge clk); in_valid = 1'b1; a = 32'd1; b = 32'd2; out_ready = 1'b0;
    @(negedge clk); a = 32'd3; b = 32'd4;
    @(negedge clk); in_valid = 1'b0;
    chk("midrst.pre_valid", 32'(out_valid), 32'd1);
    chk("midrst.pre_in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.diff", diff, 32'd0);
    chk("midrst.flags", {29'd0, borrow, zero, overflow}, 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("postrst.no_output", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b1; a = 32'd10; b = 32'd4;
    @(negedge clk); in_valid = 1'b0; chk("postrst.lat1", 32'(out_valid), 32'd0);
    @(negedge clk); chk_out("postrst.sub10_4", 32'd6, 1'b0, 1'b0, 1'b0);
    @(negedge clk); chk("postrst.bubble", 32'(out_valid), 32'd0);

    // ---- 10k random pairs with random valid/ready ----
    sent = 0;
    stall_prev = 1'b0;
    cyc_cnt = 0;
    while (sent < 10000 && cyc_cnt < 60000) begin
      ra = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      cyc($urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 3) != 0);
      if (in_valid && in_ready) sent++;
      cyc_cnt++;
    end
    chk("rand.sent", 32'(sent), 32'd10000);
    for (int i = 0; i < 50 && q.size() > 0; i++) cyc(1'b0, '0, '0, 1'b1);
    chk("rand.drained", 32'(q.size()), 32'd0);
    @(negedge clk);
    chk("rand.idle_valid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bk_subtract_pipe.md
Name: bk_subtract_pipe

Overview:
- Pipelined Brent-Kung prefix subtractor computing a - b as a + ~b + 1, with carry-in tied high in the prefix tree.
- Companion to the team's combinational Brent-Kung adder. Provides the subtract/compare direction for datapaths that need registered, flow-controlled results.
- Two register stages with valid/ready handshakes on both sides. Emits borrow, zero and signed-overflow flags alongside the difference.

Parameters:
- WIDTH, 32, operand width; power of two, >= 4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair a/b presented
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- diff  output  WIDTH  a - b modulo 2^WIDTH
- borrow  output  1  1 when unsigned a < b
- zero  output  1  1 when diff == 0
- overflow  output  1  signed two's-complement overflow of a - b

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: s1_valid = s2_valid = 0, so out_valid = 0. diff, borrow, zero and overflow clear to 0. in_ready = 1 combinationally once reset deasserts.
- Stage 1 (S1): registers G = a & ~b and P = a ^ ~b.
  - The bit-0 group generate includes carry-in = 1: G0' = G[0] | P[0].
  - S1 also registers the Brent-Kung up-sweep outputs of levels 1..log2(WIDTH)/2 (block G/P).
- Stage 2 (S2): completes the up-sweep and down-sweep (gray-cell fill) to produce carries C[i] into every bit, where C[0] = 1.
  - diff[i] = P[i] ^ C[i].
  - carry_out = G[W-1] | (P[W-1] & C[W-1]); borrow = ~carry_out.
  - overflow = (a[W-1] != b[W-1]) & (diff[W-1] != a[W-1]), using registered sign bits carried with the stage.
  - zero = ~|diff.
  - All outputs are registered in S2.
- Handshake:
  - A transfer occurs on any cycle where valid & ready are both high, on either port.
  - s2_load = ~s2_valid | out_ready.
  - s1_load = ~s1_valid | s2_load.
  - in_ready = s1_load. This is combinational from out_ready; no registered skid.
- Latency: exactly 2 cycles from input acceptance to out_valid when unstalled. Throughput is one result per cycle.
- Stall:
  - While out_valid & ~out_ready, S2 holds diff and flags stable.
  - S1 may still fill if empty. in_ready drops once both stages are valid.
  - Operands are never dropped or duplicated. Results leave in acceptance order.
- Simultaneous accept and drain with both stages full and out_ready = 1: the whole pipe advances in the same cycle and in_ready stays 1.
- Bubbles: when S1 is empty and s2_load is high, s2_valid is cleared. Data registers may keep stale values, but flags and diff are only meaningful while out_valid is high.
- Reset mid-operation: all in-flight results are discarded and out_valid drops asynchronously. No output is emitted after reset release until new operands are accepted.
- Wrap-around: diff is modulo 2^WIDTH. For example, 0 - 1 gives all-ones with borrow = 1.

Optional Feature:
- Macro: BK_SUB_SATURATE_EN.
- Defined: when overflow is 1, diff is clamped in S2:
  - 2^(W-1)-1 if a is non-negative.
  - 2^(W-1) (most-negative) if a is negative.
  - The overflow flag still reports 1.
  - borrow and zero are computed from the unclamped result.
  - No added latency.
- Undefined: diff is always the wrapped modulo result, and the clamp logic is absent.

Test Plan:
- a = 5, b = 3, out_ready = 1 -> 2 cycles later out_valid = 1, diff = 0x00000002, borrow = 0, zero = 0, overflow = 0.
- a = 3, b = 5 -> diff = 0xFFFFFFFE, borrow = 1, overflow = 0. Then a = b = 0xDEADBEEF -> diff = 0, zero = 1, borrow = 0.
- a = 0x80000000, b = 1 -> overflow = 1, borrow = 0, diff = 0x7FFFFFFF without the macro. With BK_SUB_SATURATE_EN, diff = 0x80000000. Also a = 0x7FFFFFFF, b = 0xFFFFFFFF -> overflow = 1, saturated diff = 0x7FFFFFFF.
- Back-to-back stream of 8 random pairs with out_ready held low for cycles 3-7 -> in_ready falls after two accepted pairs, diff stays stable while stalled, all 8 results emerge in order and match a golden a - b model.
- Assert rst_n = 0 while both stages are valid -> out_valid = 0 and diff/flags = 0 immediately (asynchronously). After release, no spurious output. The next accepted pair, 10 - 4, yields diff = 6 at latency 2.
- 10k random pairs with random in_valid/out_ready toggling -> every result matches {borrow, diff} = {1'b0, a} - {1'b0, b}, zero and overflow match the reference model, and no handshake violations occur.
